// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller: shadow tracker of in-flight destinations,
// load-use stall, redirect flush and EX forward selects. Optional HAZARD_PERF_CNT_EN adds counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [FWD_SEL_W-1:0]  fwd_a,
  output logic [FWD_SEL_W-1:0]  fwd_b
`ifdef HAZARD_PERF_CNT_EN
  , output logic [15:0]         stall_cnt
  , output logic [15:0]         flush_cnt
`endif
);

  logic [FWD_STAGES:0]   valid_q, valid_d;
  logic [FWD_STAGES:0]   wr_q, wr_d;
  logic [FWD_STAGES:0]   ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rd_q [FWD_STAGES:0];
  logic [REG_ADDR_W-1:0] rd_d [FWD_STAGES:0];
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d;
  logic                  use_rs_q, use_rs_d, use_rt_q, use_rt_d;

  logic load_use;
  logic live;
  logic stall;
  logic redir;

  function automatic logic hit(input logic v, input logic w,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic [REG_ADDR_W-1:0] s, input logic u);
    return v & w & (rd == s) & (s != '0) & u;
  endfunction

  // A load is unusable until it reaches LOAD_STAGE; any consumer in ID that
  // would reach EX before then has to wait.
  always_comb begin
    load_use = 1'b0;
    for (int j = 0; j <= FWD_STAGES; j++) begin
      if ((j + 1 < LOAD_STAGE) && ld_q[j] &&
          (hit(valid_q[j], wr_q[j], rd_q[j], id_rs, id_uses_rs) ||
           hit(valid_q[j], wr_q[j], rd_q[j], id_rt, id_uses_rt)))
        load_use = 1'b1;
    end
    load_use = load_use & id_valid;
  end

  assign live  = enable & ~arst;
  assign redir = live & redirect;
  assign stall = live & load_use & ~redirect;

  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;
  assign flush_if_id  = redir;
  assign flush_id_ex  = redir;
  assign flush_ex_mem = redir;

  // Walk from the oldest entry down so the nearest producer overwrites.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (valid_q[0] && !(ld_q[k] && (k < LOAD_STAGE))) begin
        if (hit(valid_q[k], wr_q[k], rd_q[k], rs_q, use_rs_q))
          fwd_a = FWD_SEL_W'(k);
        if (hit(valid_q[k], wr_q[k], rd_q[k], rt_q, use_rt_q))
          fwd_b = FWD_SEL_W'(k);
      end
    end
  end

  always_comb begin
    valid_d    = '0;
    wr_d       = '0;
    ld_d       = '0;
    valid_d[0] = id_valid & ~load_use & ~redirect;
    wr_d[0]    = id_reg_write;
    ld_d[0]    = id_mem_read;
    rd_d[0]    = id_rd;
    rs_d       = id_rs;
    rt_d       = id_rt;
    use_rs_d   = id_uses_rs;
    use_rt_d   = id_uses_rt;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      wr_d[k]    = wr_q[k-1];
      ld_d[k]    = ld_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    // The instruction leaving EX on a redirect is wrong-path as well.
    if (redirect)
      valid_d[1] = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q  <= '0;
      wr_q     <= '0;
      ld_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      use_rs_q <= 1'b0;
      use_rt_q <= 1'b0;
      for (int k = 0; k <= FWD_STAGES; k++)
        rd_q[k] <= '0;
    end else if (enable) begin
      valid_q  <= valid_d;
      wr_q     <= wr_d;
      ld_q     <= ld_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      use_rs_q <= use_rs_d;
      use_rt_q <= use_rt_d;
      for (int k = 0; k <= FWD_STAGES; k++)
        rd_q[k] <= rd_d[k];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_if_id && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: queue-based pipeline model checked every cycle,
// plus directed literal checks on a default and a 3-stage/late-load instance.
module tb_hazard_ctrl_unit;

  localparam int FS = 2;
  localparam int LS = 2;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       enable;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       redirect;

  logic       stall_pc, stall_if_id, bubble_id_ex;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_pc3, stall_if_id3, bubble_id_ex3;
  logic       flush_if_id3, flush_id_ex3, flush_ex_mem3;
  logic [1:0] fwd_a3, fwd_b3;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, stall_cnt3, flush_cnt3;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit u_dut (
    .clk(clk), .arst(arst), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .redirect(redirect), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  hazard_ctrl_unit #(.FWD_STAGES(3), .LOAD_STAGE(3)) u_dut3 (
    .clk(clk), .arst(arst), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .redirect(redirect), .stall_pc(stall_pc3), .stall_if_id(stall_if_id3),
    .bubble_id_ex(bubble_id_ex3), .flush_if_id(flush_if_id3), .flush_id_ex(flush_id_ex3),
    .flush_ex_mem(flush_ex_mem3), .fwd_a(fwd_a3), .fwd_b(fwd_b3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
  );

  // ---------------- model: pipe_q[0] is the EX instruction, pipe_q[d] is d stages older
  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
  } slot_t;

  slot_t pipe_q[$];

  function automatic logic m_hit(input slot_t e, input logic [4:0] s, input logic u);
    return e.valid && e.rw && (e.rd == s) && (s != 5'd0) && u;
  endfunction

  function automatic logic m_load_use();
    logic r;
    r = 1'b0;
    for (int d = 0; d <= LS - 2; d++)
      if (pipe_q[d].ld && (m_hit(pipe_q[d], id_rs, id_uses_rs) || m_hit(pipe_q[d], id_rt, id_uses_rt)))
        r = 1'b1;
    return id_valid && r;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] s, input logic u);
    if (!pipe_q[0].valid) return 2'd0;
    for (int d = 1; d <= FS; d++)
      if (m_hit(pipe_q[d], s, u) && !(pipe_q[d].ld && d < LS))
        return 2'(d);
    return 2'd0;
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    for (int d = 0; d <= FS; d++) pipe_q.push_back('0);
  endtask

  task automatic model_advance();
    slot_t n;
    logic  lu;
    lu = m_load_use();
    n  = '0;
    if (id_valid && !lu && !redirect)
      n = '{valid: 1'b1, rw: id_reg_write, ld: id_mem_read, rd: id_rd,
            rs: id_rs, rt: id_rt, urs: id_uses_rs, urt: id_uses_rt};
    pipe_q.push_front(n);
    if (redirect) pipe_q[1].valid = 1'b0;
    while (pipe_q.size() > FS + 1) void'(pipe_q.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge arst);
      if (arst) model_reset();
      else if (enable) model_advance();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison of the default instance against the model.
  initial begin
    logic       live, st, fl;
    logic [11:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      live  = enable && !arst;
      st    = live && m_load_use() && !redirect;
      fl    = live && redirect;
      exp_v = {st, st, st, fl, fl, fl, 2'b00, m_fwd(pipe_q[0].rs, pipe_q[0].urs), m_fwd(pipe_q[0].rt, pipe_q[0].urt)};
      act_v = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, 2'b00, fwd_a, fwd_b};
      chk("cycle_ctrl", 32'(act_v), 32'(exp_v));
    end
  end

  // ---------------- drivers
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic lw_r2();      // lw r2,0(r1)
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
  endtask

  task automatic add_r4_r2();  // add r4,r2,r2
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
  endtask

  initial begin
    enable = 1'b1;
    redirect = 1'b1;
    idle();
    tick();
    at_neg();
    chk("rst_flush_blocked", 32'(flush_if_id), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_stall", 32'(stall_pc3), 32'd0);
    redirect = 1'b0;
    tick();
    arst = 1'b0;

    // add r3,r1,r2 ; sub r5,r3,r4
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    at_neg();
    chk("b2b_no_stall", 32'(stall_pc), 32'd0);
    tick();
    idle();
    at_neg();
    chk("b2b_fwd_a", 32'(fwd_a), 32'd1);
    chk("b2b_fwd_b", 32'(fwd_b), 32'd0);
    drain();

    // add r3 ; or r6,r7,r8 ; sub r5,r3,r4
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    idle();
    at_neg();
    chk("gap1_fwd_a", 32'(fwd_a), 32'd2);
    drain();

    // load-use
    lw_r2();
    tick();
    add_r4_r2();
    at_neg();
    chk("lu_stall_pc", 32'(stall_pc), 32'd1);
    chk("lu_stall_if_id", 32'(stall_if_id), 32'd1);
    chk("lu_bubble", 32'(bubble_id_ex), 32'd1);
    tick();
    at_neg();
    chk("lu_one_cycle", 32'(stall_pc), 32'd0);
    tick();
    idle();
    at_neg();
    chk("lu_fwd_a", 32'(fwd_a), 32'd2);
    chk("lu_fwd_b", 32'(fwd_b), 32'd2);
    drain();

    // register 0
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    at_neg();
    chk("r0_no_stall", 32'(stall_pc), 32'd0);
    tick();
    idle();
    at_neg();
    chk("r0_fwd_a", 32'(fwd_a), 32'd0);
    chk("r0_fwd_b", 32'(fwd_b), 32'd0);
    drain();

    // redirect during load-use stall
    lw_r2();
    tick();
    add_r4_r2();
    redirect = 1'b1;
    at_neg();
    chk("rd_stall_pc", 32'(stall_pc), 32'd0);
    chk("rd_bubble", 32'(bubble_id_ex), 32'd0);
    chk("rd_flush", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'h7);
    tick();
    redirect = 1'b0;
    at_neg();
    chk("rd_load_gone", 32'(stall_pc), 32'd0);
    chk("rd_fwd_a", 32'(fwd_a), 32'd0);
    tick();
    idle();
    at_neg();
    chk("rd_no_late_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    drain();

    // enable low freezes the tracker and masks stall
    lw_r2();
    tick();
    add_r4_r2();
    enable = 1'b0;
    at_neg();
    chk("en0_stall_masked", 32'(stall_pc), 32'd0);
    tick();
    tick();
    enable = 1'b1;
    at_neg();
    chk("en1_stall_held", 32'(stall_pc), 32'd1);
    tick();
    tick();
    idle();
    at_neg();
    chk("en1_fwd_a", 32'(fwd_a), 32'd2);
    drain();

    // reset mid-stall
    lw_r2();
    tick();
    add_r4_r2();
    at_neg();
    chk("rms_stall_before", 32'(stall_pc), 32'd1);
    arst = 1'b1;
    #1;
    chk("rms_ctrl_zero", 32'({stall_pc, stall_if_id, bubble_id_ex, fwd_a, fwd_b}), 32'd0);
    tick();
    arst = 1'b0;
    at_neg();
    chk("rms_tracker_empty", 32'(stall_pc), 32'd0);
    drain();

    // 3 forwarding stages, load data at stage 3
    arst = 1'b1;
    tick();
    arst = 1'b0;
    lw_r2();
    tick();
    add_r4_r2();
    at_neg();
    chk("f3_stall_1", 32'(stall_pc3), 32'd1);
    tick();
    at_neg();
    chk("f3_stall_2", 32'(stall_pc3), 32'd1);
    tick();
    at_neg();
    chk("f3_stall_clear", 32'(stall_pc3), 32'd0);
    tick();
    idle();
    at_neg();
    chk("f3_fwd_a", 32'(fwd_a3), 32'd3);
    chk("f3_fwd_b", 32'(fwd_b3), 32'd3);
`ifdef HAZARD_PERF_CNT_EN
    chk("f3_stall_cnt", 32'(stall_cnt3), 32'd2);
    chk("f3_flush_cnt", 32'(flush_cnt3), 32'd0);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
